axis_header_sched: RTL and testbench

//  Round-robin scheduler that shares one header-insert datapath between NUM_SRC header requesters.
//  Per packet: grants one source, presents its header on the insert port and holds the grant until the last beat passes.
//  The last beat is seen by snooping the downstream AXI-Stream output handshake. Releases, then re-arbitrates.

---
 rtl/axis_hdr_pkg.sv | 27 ++
 rtl/axis_rr_arb.sv | 31 +++
 rtl/axis_header_sched.sv | 162 ++++++++++++++++
 tb/tb_axis_header_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and keep helpers for the header scheduler.
// Helpers take keep zero-extended to KEEP_MAX bits so one function serves any data width.
package axis_hdr_pkg;

    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        PKT   = 2'd2
    } state_t;

    // Legal keep is non-zero and a solid run of ones starting at bit 0.
    function automatic logic keep_ok(input logic [KEEP_MAX-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX'(1))) == '0);
    endfunction

    function automatic logic [7:0] keep_popcnt(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + {7'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Latency: combinational. Backpressure: none, caller decides when grant is used.
// Ties resolved purely by ptr; no state held here.
module axis_rr_arb #(
    parameter int NUM_SRC   = 4,
    parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_ID_WD-1:0] ptr,
    output logic [NUM_SRC-1:0]   gnt,
    output logic [SRC_ID_WD-1:0] idx
);

    always_comb begin : p_arb
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = (int'(ptr) + i) % NUM_SRC;
            if (!found && req[SRC_ID_WD'(j)]) begin
                found                = 1'b1;
                gnt[SRC_ID_WD'(j)]   = 1'b1;
                idx                  = SRC_ID_WD'(j);
            end
        end
    end

endmodule

// File: rtl/axis_header_sched.sv
// Round-robin header scheduler feeding one insert port; grant held until the snooped last beat.
// Latency: req_ready same cycle as grant, valid_insert one cycle later. Optional watchdog: HDR_TIMEOUT_EN.
// Backpressure: header held stable while ready_insert is low; no new grant until the packet ends.
module axis_header_sched
    import axis_hdr_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD/8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int SRC_ID_WD    = $clog2(NUM_SRC)
`ifdef HDR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = 1024
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               req_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]       req_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]  req_keep,
    output logic [NUM_SRC-1:0]               req_ready,
    output logic                             valid_insert,
    output logic [DATA_WD-1:0]               data_insert,
    output logic [DATA_BYTE_WD-1:0]          keep_insert,
    output logic [BYTE_CNT_WD-1:0]           byte_insert_cnt,
    input  logic                             ready_insert,
    input  logic                             pkt_valid,
    input  logic                             pkt_ready,
    input  logic                             pkt_last,
    output logic [SRC_ID_WD-1:0]             grant_id,
    output logic                             busy,
    output logic                             hdr_err
`ifdef HDR_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    state_t                  r_state;
    state_t                  w_nxt;
    logic [SRC_ID_WD-1:0]    r_ptr;
    logic [SRC_ID_WD-1:0]    w_idx;
    logic [NUM_SRC-1:0]      w_gnt;
    logic                    w_grant;
    logic                    w_kok;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_tmo;
    logic [DATA_WD-1:0]      w_data;
    logic [DATA_BYTE_WD-1:0] w_keep;
    logic [KEEP_MAX-1:0]     w_keep_ext;
    logic [DATA_WD-1:0]      r_data;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic [BYTE_CNT_WD-1:0]  r_cnt;
    logic [SRC_ID_WD-1:0]    r_grant_id;
    logic                    r_hdr_err;

    axis_rr_arb #(
        .NUM_SRC   (NUM_SRC),
        .SRC_ID_WD (SRC_ID_WD)
    ) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // Gating with rst keeps req_ready quiet while reset is held.
    assign w_grant = !rst && (r_state == IDLE) && (|req_valid);
    assign w_data  = req_data[w_idx*DATA_WD +: DATA_WD];
    assign w_keep  = req_keep[w_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign w_kok   = keep_ok(w_keep_ext);
    assign w_beat  = pkt_valid && pkt_ready;
    assign w_last  = (r_state == PKT) && w_beat && pkt_last;

    always_comb begin
        w_keep_ext                   = '0;
        w_keep_ext[DATA_BYTE_WD-1:0] = w_keep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant && w_kok)  w_nxt = OFFER;
            OFFER:   if (ready_insert)      w_nxt = PKT;
            PKT:     if (w_last || w_tmo)   w_nxt = IDLE;
            default:                        w_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_insert = (r_state == OFFER);
        busy         = (r_state != IDLE);
        req_ready    = w_grant ? w_gnt : '0;
    end

    // Malformed headers are consumed and advance the pointer but never reach the insert regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_data     <= '0;
            r_keep     <= '0;
            r_cnt      <= '0;
            r_grant_id <= '0;
            r_hdr_err  <= 1'b0;
        end else begin
            r_hdr_err <= w_grant && !w_kok;
            if (w_grant) begin
                r_ptr <= (w_idx == SRC_ID_WD'(NUM_SRC-1)) ? '0 : w_idx + SRC_ID_WD'(1);
                if (w_kok) begin
                    r_data     <= w_data;
                    r_keep     <= w_keep;
                    r_cnt      <= BYTE_CNT_WD'(keep_popcnt(w_keep_ext) - 8'd1);
                    r_grant_id <= w_idx;
                end
            end
        end
    end

    assign data_insert     = r_data;
    assign keep_insert     = r_keep;
    assign byte_insert_cnt = r_cnt;
    assign grant_id        = r_grant_id;
    assign hdr_err         = r_hdr_err;

`ifdef HDR_TIMEOUT_EN
    localparam int WD_WD = $clog2(TIMEOUT_CYC);

    logic [WD_WD-1:0] r_wdog;
    logic             r_tmo_err;

    assign w_tmo = (r_state == PKT) && !w_beat && (r_wdog == WD_WD'(TIMEOUT_CYC-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_tmo;
            if (((r_state == OFFER) && ready_insert) || w_beat) begin
                r_wdog <= '0;
            end else if (r_state == PKT) begin
                r_wdog <= r_wdog + WD_WD'(1);
            end
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_axis_header_sched.sv
// Directed bench for axis_header_sched: arbitration order, header hold, keep checks, release and reset.
// Inputs change 1 ns after the rising edge; outputs are checked in that same window.
module tb_axis_header_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [15:0]  req_keep;
    logic [3:0]   req_ready;
    logic         valid_insert;
    logic [31:0]  data_insert;
    logic [3:0]   keep_insert;
    logic [1:0]   byte_insert_cnt;
    logic         ready_insert;
    logic         pkt_valid;
    logic         pkt_ready;
    logic         pkt_last;
    logic [1:0]   grant_id;
    logic         busy;
    logic         hdr_err;
`ifdef HDR_TIMEOUT_EN
    logic         timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_header_sched #(
        .NUM_SRC (4),
        .DATA_WD (32)
`ifdef HDR_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_keep        (req_keep),
        .req_ready       (req_ready),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_last        (pkt_last),
        .grant_id        (grant_id),
        .busy            (busy),
        .hdr_err         (hdr_err)
`ifdef HDR_TIMEOUT_EN
        ,
        .timeout_err     (timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] d, input logic [3:0] k);
        req_data[i*32 +: 32] = d;
        req_keep[i*4 +: 4]   = k;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = '0;
        ready_insert = 1'b0;
        pkt_valid    = 1'b0;
        pkt_ready    = 1'b0;
        pkt_last     = 1'b0;
        step();
        step();
    endtask

    // Expects src id to win in the current IDLE cycle, then checks the offered header.
    task automatic grant(input int id, input logic [31:0] d, input logic [3:0] k, input logic [1:0] cnt);
        logic [3:0] onehot;
        onehot = 4'b0001 << id;
        #1;
        check($sformatf("req_ready_src%0d", id), 64'(req_ready), 64'(onehot));
        step();
        req_valid[id] = 1'b0;
        check($sformatf("valid_insert_src%0d", id), 64'(valid_insert), 64'd1);
        check($sformatf("grant_id_src%0d", id), 64'(grant_id), 64'(id));
        check($sformatf("data_insert_src%0d", id), 64'(data_insert), 64'(d));
        check($sformatf("keep_insert_src%0d", id), 64'(keep_insert), 64'(k));
        check($sformatf("byte_cnt_src%0d", id), 64'(byte_insert_cnt), 64'(cnt));
        check($sformatf("req_ready_offer_src%0d", id), 64'(req_ready), 64'd0);
    endtask

    task automatic send_pkt(input int nbeats);
        ready_insert = 1'b1;
        step();
        ready_insert = 1'b0;
        check("vi_drop_in_pkt", 64'(valid_insert), 64'd0);
        check("busy_in_pkt", 64'(busy), 64'd1);
        for (int b = 0; b < nbeats; b++) begin
            pkt_valid = 1'b1;
            pkt_ready = 1'b1;
            pkt_last  = (b == nbeats - 1);
            step();
            check($sformatf("busy_after_beat%0d", b), 64'(busy), (b == nbeats - 1) ? 64'd0 : 64'd1);
        end
        pkt_valid = 1'b0;
        pkt_ready = 1'b0;
        pkt_last  = 1'b0;
    endtask

    initial begin
        req_data = '0;
        req_keep = '0;
        do_reset();
        check("rst_valid_insert", 64'(valid_insert), 64'd0);
        check("rst_data_insert", 64'(data_insert), 64'd0);
        check("rst_keep_insert", 64'(keep_insert), 64'd0);
        check("rst_byte_cnt", 64'(byte_insert_cnt), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hdr_err", 64'(hdr_err), 64'd0);
        rst = 1'b0;

        // single source, header held while insert block stalls
        set_src(0, 32'hA5A5A5A5, 4'b1111);
        req_valid = 4'b0001;
        check("t1_busy_idle", 64'(busy), 64'd0);
        grant(0, 32'hA5A5A5A5, 4'b1111, 2'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t1_hold_vi%0d", c), 64'(valid_insert), 64'd1);
            check($sformatf("t1_hold_data%0d", c), 64'(data_insert), 64'hA5A5A5A5);
        end
        send_pkt(2);

        // round robin from a fresh pointer, then wrap
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 32'h11111111 * (i + 1), 4'b1111);
        req_valid = 4'b1111;
        grant(0, 32'h11111111, 4'b1111, 2'd3);
        send_pkt(2);
        grant(1, 32'h22222222, 4'b1111, 2'd3);
        send_pkt(2);
        grant(2, 32'h33333333, 4'b1111, 2'd3);
        send_pkt(2);
        grant(3, 32'h44444444, 4'b1111, 2'd3);
        send_pkt(2);
        req_valid = 4'b1111;
        grant(0, 32'h11111111, 4'b1111, 2'd3);
        req_valid = 4'b0000;
        send_pkt(2);
        req_valid = 4'b0001;
        grant(0, 32'h11111111, 4'b1111, 2'd3);
        send_pkt(2);

        // malformed keep is consumed and flagged, nothing offered
        set_src(2, 32'hDEADBEEF, 4'b0101);
        req_valid = 4'b0100;
        #1;
        check("t3_req_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = 4'b0000;
        check("t3_hdr_err", 64'(hdr_err), 64'd1);
        check("t3_valid_insert", 64'(valid_insert), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        step();
        check("t3_hdr_err_pulse", 64'(hdr_err), 64'd0);
        check("t3_valid_insert2", 64'(valid_insert), 64'd0);

        // two-byte keep, last ignored outside PKT, release needs pkt_ready
        set_src(1, 32'h0000BEEF, 4'b0011);
        req_valid = 4'b0010;
        grant(1, 32'h0000BEEF, 4'b0011, 2'd1);
        pkt_valid = 1'b1;
        pkt_ready = 1'b1;
        pkt_last  = 1'b1;
        step();
        check("t4_offer_last_busy", 64'(busy), 64'd1);
        check("t4_offer_last_vi", 64'(valid_insert), 64'd1);
        ready_insert = 1'b1;
        step();
        ready_insert = 1'b0;
        check("t4_same_cycle_last", 64'(busy), 64'd1);
        check("t4_vi_drop", 64'(valid_insert), 64'd0);
        pkt_ready = 1'b0;
        step();
        check("t4_last_no_ready", 64'(busy), 64'd1);
        pkt_ready = 1'b1;
        step();
        pkt_valid = 1'b0;
        pkt_ready = 1'b0;
        pkt_last  = 1'b0;
        check("t4_release", 64'(busy), 64'd0);

        // reset in PKT clears everything; src0 wins first afterwards
        set_src(2, 32'h12345678, 4'b0111);
        req_valid = 4'b0100;
        grant(2, 32'h12345678, 4'b0111, 2'd2);
        ready_insert = 1'b1;
        step();
        ready_insert = 1'b0;
        check("t5_in_pkt", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        check("t5_rst_vi", 64'(valid_insert), 64'd0);
        check("t5_rst_data", 64'(data_insert), 64'd0);
        check("t5_rst_keep", 64'(keep_insert), 64'd0);
        check("t5_rst_cnt", 64'(byte_insert_cnt), 64'd0);
        check("t5_rst_gid", 64'(grant_id), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_hdr_err", 64'(hdr_err), 64'd0);
        check("t5_rst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 32'hC0DE0000 + i, 4'b1111);
        req_valid = 4'b1111;
        grant(0, 32'hC0DE0000, 4'b1111, 2'd3);
        req_valid = 4'b0000;
        send_pkt(1);

`ifdef HDR_TIMEOUT_EN
        // watchdog: no beats for 16 cycles in PKT forces release
        req_valid = 4'b0010;
        grant(1, 32'hC0DE0001, 4'b1111, 2'd3);
        ready_insert = 1'b1;
        step();
        ready_insert = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            check($sformatf("t6_wait%0d", c), 64'({busy, timeout_err}), 64'b10);
        end
        step();
        check("t6_timeout_err", 64'(timeout_err), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        step();
        check("t6_timeout_pulse", 64'(timeout_err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
